rr_arbiter16: RTL and testbench

RR_ARBITER16 -- requirements
Module: rr_arbiter16

---
 rtl/rr_arbiter16_pkg.sv | 12 +
 rtl/rr_arbiter16_if.sv | 30 +++
 rtl/rr_pick.sv | 31 +++
 rtl/rr_arbiter16.sv | 82 ++++++++
 tb/tb_rr_arbiter16.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/rr_arbiter16_pkg.sv
// Shared sizes and state encoding for the 16-way round-robin arbiter.
package rr_arbiter16_pkg;

  localparam int unsigned NREQ  = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter16_if;
  import rr_arbiter16_pkg::*;

  logic [NREQ-1:0]  req;
  logic             done;
  logic [NREQ-1:0]  gnt_onehot;
  logic [IDX_W-1:0] gnt_bin;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt_onehot,
    input  gnt_bin,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt_onehot,
    output gnt_bin,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping 15->0.
module rr_pick
  import rr_arbiter16_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan upward from ptr; the 4-bit candidate index wraps modulo 16 naturally.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    cand   = '0;
    any    = |req;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    onehot = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with hold-time limit and timeout pulse.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter16_if.slave bus
);

  localparam int unsigned     CNT_W    = 8;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [NREQ-1:0]  win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             release_req;
  logic             hold_lim;

  rr_pick u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  // Grant exit causes: voluntary release (done or request dropped) vs hold limit.
  always_comb begin
    release_req = bus.done || !bus.req[bus.gnt_bin];
    hold_lim    = (hold_cnt == HOLD_LIM);
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      hold_cnt       <= '0;
      bus.gnt_onehot <= '0;
      bus.gnt_bin    <= '0;
      bus.gnt_valid  <= 1'b0;
      bus.timeout    <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            state          <= GRANT;
            bus.gnt_onehot <= win_onehot;
            bus.gnt_bin    <= win_idx;
            bus.gnt_valid  <= 1'b1;
            hold_cnt       <= '0;
          end
        end
        GRANT: begin
          if (release_req || hold_lim) begin
            state          <= IDLE;
            bus.gnt_onehot <= '0;
            bus.gnt_bin    <= '0;
            bus.gnt_valid  <= 1'b0;
            ptr            <= bus.gnt_bin + IDX_W'(1);
            // Timeout only when the hold limit alone forced the revoke.
            bus.timeout    <= hold_lim && !release_req;
          end else if (hold_cnt != CNT_SAT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 with hand-computed expected grants.
module tb_rr_arbiter16;
  import rr_arbiter16_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(.HOLD_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_timeout);
    check({tag, "_valid"},   32'(bus.gnt_valid), 32'd0);
    check({tag, "_onehot"},  32'(bus.gnt_onehot), 32'd0);
    check({tag, "_bin"},     32'(bus.gnt_bin), 32'd0);
    check({tag, "_timeout"}, 32'(bus.timeout), 32'(exp_timeout));
  endtask

  task automatic check_grant(input string tag, input int idx);
    check({tag, "_valid"},  32'(bus.gnt_valid), 32'd1);
    check({tag, "_bin"},    32'(bus.gnt_bin), 32'(idx));
    check({tag, "_onehot"}, 32'(bus.gnt_onehot), 32'(32'd1 << idx));
    check({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.req  = 16'hFFFF;
    bus.done = 1'b0;

    // Reset held across edges with all requests active.
    step();
    step();
    check_idle("rst_hold", 1'b0);

    // First grant after release comes from ptr=0.
    rst = 1'b0;
    step();
    check_grant("rst_first", 0);

    // Rotation through all 16 requesters with done held high.
    bus.done = 1'b1;
    step();
    check_idle("rot_idle0", 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step();
      check_grant($sformatf("rot_g%0d", k), k % 16);
      step();
      check_idle($sformatf("rot_i%0d", k), 1'b0);
    end
    bus.req  = 16'h0000;
    bus.done = 1'b0;
    step();
    check_idle("idle_noreq", 1'b0);

    // Position ptr at 14 via a grant of 13 released by dropping its request.
    bus.req = 16'h2000;
    step();
    check_grant("pre_wrap", 13);
    bus.req = 16'h0000;
    step();
    check_idle("req_drop", 1'b0);

    // Wrap: ptr=14 with req bits 0 and 2.
    bus.req = 16'h0005;
    step();
    check_grant("wrap_b0", 0);
    bus.done = 1'b1;
    step();
    check_idle("wrap_i0", 1'b0);
    step();
    check_grant("wrap_b2", 2);
    step();
    check_idle("wrap_i2", 1'b0);
    // ptr should now be 3: bits 0 and 3 requested, 3 wins.
    bus.req  = 16'h0009;
    bus.done = 1'b0;
    step();
    check_grant("ptr_at3", 3);
    bus.req = 16'h0000;
    step();
    check_idle("ptr_at3_rel", 1'b0);

    // Timeout: bit 4 held, done low, 8 grant cycles then a timeout pulse.
    bus.req = 16'h0010;
    step();
    for (int c = 0; c < 8; c++) begin
      check_grant($sformatf("hold_c%0d", c), 4);
      step();
    end
    check_idle("tmo", 1'b1);
    step();
    check_grant("tmo_regrant", 4);

    // done on the 8th grant cycle coinciding with the hold limit: no timeout.
    for (int c = 1; c < 8; c++) step();
    check_grant("sim_c8", 4);
    bus.done = 1'b1;
    step();
    check_idle("sim_rel", 1'b0);
    bus.done = 1'b0;
    bus.req  = 16'h0000;
    step();
    check_idle("sim_after", 1'b0);

    // Reset mid-grant of bit 9 clears outputs without a clock edge.
    bus.req = 16'h0200;
    step();
    check_grant("pre_rst9", 9);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst", 1'b0);
    bus.req  = 16'h0208;
    bus.done = 1'b1;
    step();
    check_idle("rst_hold2", 1'b0);
    bus.done = 1'b0;
    rst      = 1'b0;
    step();
    check_grant("post_rst_ptr0", 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
